rs_mul_param: RTL and testbench
===============================

# rs_mul_param

Parametrised multiplier reservation station with ENT_NUM entries. It sits between dispatch and the multiply unit, and allocates its own free entries for up to two dispatched instructions per cycle. It wakes up operands from FWD_NUM result-forwarding buses and selects one ready entry per cycle to issue under a valid/ack handshake. It applies branch-speculation kill (prmiss) and speculation resolve (prsuccess) to every entry.

## Interface
- ENT_NUM, 4: entry count, ≥2.
- ENT_SEL, $clog2(ENT_NUM): entry index width.
- DATA_LEN, 32: operand width.
- RRF_SEL, 6: rename-register tag width.
- SPECTAG_LEN, 5: one-hot speculation tag width.
- FWD_NUM, 5: number of forwarding buses.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- prmiss / prsuccess  in  1 each  branch mispredict / branch resolved correct.
- prtag, specfixtag  in  SPECTAG_LEN each  resolved tag; kill mask.
- we1, we2  in  1 each  dispatch slot write requests.
- wsrcA_k, wsrcB_k  in  DATA_LEN  operand value, or tag in bits [RRF_SEL-1:0] when not valid (k=1,2).
- wvalidA_k, wvalidB_k, wdstval_k, wspecbit_k, wsrcA_signed_k, wsrcB_signed_k, wsel_lohi_k  in  1 each  slot-k fields.
- wrrftag_k  in  RRF_SEL  slot-k destination tag.
- wspectag_k  in  SPECTAG_LEN  slot-k speculation tag.
- alloc_rdy  out  1  ≥2 entries free.
- busyvec  out  ENT_NUM  entry occupied.
- exrslt  in  FWD_NUM*DATA_LEN  result buses, bus j at [j*DATA_LEN +: DATA_LEN].
- exdst  in  FWD_NUM*RRF_SEL  result tags.
- kill_spec  in  FWD_NUM  bus j result is killed; no wakeup from it.
- issue_valid  out  1  an entry is presented for issue.
- issue_ack  in  1  multiplier accepts the presented entry.
- issue_addr  out  ENT_SEL  presented entry index.
- ex_srcA, ex_srcB  out  DATA_LEN  presented operands.
- ex_rrftag  out  RRF_SEL  presented entry field.
- ex_dstval, ex_specbit, ex_srcA_signed, ex_srcB_signed, ex_sel_lohi  out  1 each  presented entry fields.
- ex_spectag  out  SPECTAG_LEN  presented entry field.

## Operation
- Allocation: slot 1 takes the lowest-index free entry, and slot 2 takes the next lowest. Allocation uses busyvec at the start of the cycle; an entry freed this cycle is not reused until the next cycle.
- A slot 2 write without a slot 1 write still takes the second-lowest free entry.
- Dispatch asserts weN only when alloc_rdy=1. Writes are ignored while alloc_rdy=0.
- Wakeup, per operand: a match occurs when the operand is not valid, exdst[j] equals the stored tag, and kill_spec[j]=0. On a match the operand captures exrslt[j] and sets valid at the next edge. If several buses match, the lowest j wins.
- Entry ready: busy and, for each operand, either valid or matching a bus this cycle.
- ex_srcA/B present the forwarded value when it arrives this cycle, otherwise the stored value.
- Selection: one ready entry is presented per cycle. issue_valid = any entry ready and prmiss=0.
- Issue handshake: when issue_valid & issue_ack, the presented entry's busy bit clears at the next edge. Without ack the entry stays, and it may be re-selected next cycle.
- prmiss:
  - busy clears for every entry with (spectag & specfixtag) != 0.
  - All specbits clear.
  - Writes and acks in the same cycle are ignored.
- prsuccess:
  - Specbit clears for every entry with spectag == prtag.
  - Writes and acks in the same cycle proceed normally.
  - ex_specbit reflects the cleared value in that same cycle.
- When issue_valid=0, all ex_* outputs and issue_addr are 0.

## Timing
- Reset values:
  - busyvec=0, all specbits and valid bits 0, all entry fields 0.
  - issue_valid=0, ex_* = 0.
  - alloc_rdy=1.
- Write at edge t: the entry is busy from t+1. If both operands are valid on write, issue_valid can assert in cycle t+1.
- Forward in cycle c to the last missing operand: issue_valid in cycle c, with the bypassed value on ex_src.
- Ack at cycle c: the entry is free from c+1, and alloc_rdy reflects this in c+1.
- alloc_rdy and issue_valid are combinational from state and forwarding inputs. No other comb path from issue_ack.

## Configuration
- RS_MUL_AGE_SELECT_EN defined:
  - Oldest-ready selection via an ENT_NUM×ENT_NUM age matrix.
  - Entries written earlier are older.
  - In a dual write, slot 1 is older than slot 2.
  - A written entry becomes younger than all currently busy entries.
- Undefined: the lowest-index ready entry is selected, and no age state exists.

## Test plan
- Reset, then dual write with both operands valid, values 6 and 7, sel_lohi=0 → cycle t+1: issue_valid=1, issue_addr=0, ex_srcA=6, ex_srcB=7. The ack frees entry 0 and busyvec=4'b0010.
- Write an entry with srcA tag 9 not valid. exdst bus 3 carries 9 with kill_spec3=0 and exrslt 0x55 → issue_valid in the same cycle with ex_srcA=0x55. Repeat with kill_spec3=1 → no wakeup.
- Fill all 4 entries → alloc_rdy=0. Ack one → alloc_rdy is still 0 (3 busy). Ack a second → alloc_rdy=1.
- Entries with spectag 5'b00010 and 5'b00001; prmiss with specfixtag=5'b00010 → only the first entry is freed, and a same-cycle we1 is ignored.
- prsuccess with prtag=5'b00001 while an entry is presented → ex_specbit=0 in that cycle, and a same-cycle write is accepted.
- With the macro, write entry 2 before entry 0, then make both ready together → issue_addr=2. Without the macro → issue_addr=0.

Source files
------------

// File: rtl/rs_mul_param.sv
// rs_mul_param: multiplier reservation station with dual dispatch, forwarding wakeup and speculation kill.
// Define RS_MUL_AGE_SELECT_EN for oldest-ready issue selection; default picks the lowest-index ready entry.
module rs_mul_param #(
  parameter int ENT_NUM     = 4,
  parameter int ENT_SEL     = $clog2(ENT_NUM),
  parameter int DATA_LEN    = 32,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5,
  parameter int FWD_NUM     = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        prmiss,
  input  logic                        prsuccess,
  input  logic [SPECTAG_LEN-1:0]      prtag,
  input  logic [SPECTAG_LEN-1:0]      specfixtag,
  input  logic                        we1,
  input  logic                        we2,
  input  logic [DATA_LEN-1:0]         wsrcA_1,
  input  logic [DATA_LEN-1:0]         wsrcB_1,
  input  logic                        wvalidA_1,
  input  logic                        wvalidB_1,
  input  logic                        wdstval_1,
  input  logic                        wspecbit_1,
  input  logic                        wsrcA_signed_1,
  input  logic                        wsrcB_signed_1,
  input  logic                        wsel_lohi_1,
  input  logic [RRF_SEL-1:0]          wrrftag_1,
  input  logic [SPECTAG_LEN-1:0]      wspectag_1,
  input  logic [DATA_LEN-1:0]         wsrcA_2,
  input  logic [DATA_LEN-1:0]         wsrcB_2,
  input  logic                        wvalidA_2,
  input  logic                        wvalidB_2,
  input  logic                        wdstval_2,
  input  logic                        wspecbit_2,
  input  logic                        wsrcA_signed_2,
  input  logic                        wsrcB_signed_2,
  input  logic                        wsel_lohi_2,
  input  logic [RRF_SEL-1:0]          wrrftag_2,
  input  logic [SPECTAG_LEN-1:0]      wspectag_2,
  output logic                        alloc_rdy,
  output logic [ENT_NUM-1:0]          busyvec,
  input  logic [FWD_NUM*DATA_LEN-1:0] exrslt,
  input  logic [FWD_NUM*RRF_SEL-1:0]  exdst,
  input  logic [FWD_NUM-1:0]          kill_spec,
  output logic                        issue_valid,
  input  logic                        issue_ack,
  output logic [ENT_SEL-1:0]          issue_addr,
  output logic [DATA_LEN-1:0]         ex_srcA,
  output logic [DATA_LEN-1:0]         ex_srcB,
  output logic [RRF_SEL-1:0]          ex_rrftag,
  output logic                        ex_dstval,
  output logic                        ex_specbit,
  output logic                        ex_srcA_signed,
  output logic                        ex_srcB_signed,
  output logic                        ex_sel_lohi,
  output logic [SPECTAG_LEN-1:0]      ex_spectag
);

  typedef struct packed {
    logic [DATA_LEN-1:0]    src_a;
    logic [DATA_LEN-1:0]    src_b;
    logic                   valid_a;
    logic                   valid_b;
    logic [RRF_SEL-1:0]     rrftag;
    logic                   dstval;
    logic                   specbit;
    logic [SPECTAG_LEN-1:0] spectag;
    logic                   a_signed;
    logic                   b_signed;
    logic                   sel_lohi;
  } ent_t;

  ent_t                ent [ENT_NUM];
  logic [ENT_NUM-1:0]  busy;
  ent_t                wdata1, wdata2;
  logic [ENT_NUM-1:0]  hit_a, hit_b, ready;
  logic [DATA_LEN-1:0] fwd_a [ENT_NUM];
  logic [DATA_LEN-1:0] fwd_b [ENT_NUM];
  logic [ENT_SEL-1:0]  alloc1, alloc2, sel;
  logic                wr1, wr2;

  assign wdata1 = '{src_a: wsrcA_1, src_b: wsrcB_1, valid_a: wvalidA_1, valid_b: wvalidB_1,
                    rrftag: wrrftag_1, dstval: wdstval_1, specbit: wspecbit_1, spectag: wspectag_1,
                    a_signed: wsrcA_signed_1, b_signed: wsrcB_signed_1, sel_lohi: wsel_lohi_1};
  assign wdata2 = '{src_a: wsrcA_2, src_b: wsrcB_2, valid_a: wvalidA_2, valid_b: wvalidB_2,
                    rrftag: wrrftag_2, dstval: wdstval_2, specbit: wspecbit_2, spectag: wspectag_2,
                    a_signed: wsrcA_signed_2, b_signed: wsrcB_signed_2, sel_lohi: wsel_lohi_2};

  assign busyvec = busy;

  // Wakeup: first matching bus (lowest j) supplies the operand.
  always_comb begin
    logic ha, hb;
    for (int unsigned i = 0; i < ENT_NUM; i++) begin
      ha       = 1'b0;
      hb       = 1'b0;
      fwd_a[i] = '0;
      fwd_b[i] = '0;
      for (int unsigned j = 0; j < FWD_NUM; j++) begin
        if (!ha && busy[i] && !ent[i].valid_a && !kill_spec[j] &&
            exdst[j*RRF_SEL +: RRF_SEL] == ent[i].src_a[RRF_SEL-1:0]) begin
          ha       = 1'b1;
          fwd_a[i] = exrslt[j*DATA_LEN +: DATA_LEN];
        end
        if (!hb && busy[i] && !ent[i].valid_b && !kill_spec[j] &&
            exdst[j*RRF_SEL +: RRF_SEL] == ent[i].src_b[RRF_SEL-1:0]) begin
          hb       = 1'b1;
          fwd_b[i] = exrslt[j*DATA_LEN +: DATA_LEN];
        end
      end
      hit_a[i] = ha;
      hit_b[i] = hb;
      ready[i] = busy[i] & (ent[i].valid_a | ha) & (ent[i].valid_b | hb);
    end
  end

  always_comb begin
    logic f1, f2;
    f1     = 1'b0;
    f2     = 1'b0;
    alloc1 = '0;
    alloc2 = '0;
    for (int unsigned i = 0; i < ENT_NUM; i++) begin
      if (!busy[i]) begin
        if (!f1) begin
          alloc1 = ENT_SEL'(i);
          f1     = 1'b1;
        end else if (!f2) begin
          alloc2 = ENT_SEL'(i);
          f2     = 1'b1;
        end
      end
    end
    alloc_rdy = f2;
  end

  assign wr1 = we1 & alloc_rdy & ~prmiss;
  assign wr2 = we2 & alloc_rdy & ~prmiss;

`ifdef RS_MUL_AGE_SELECT_EN
  // older[i][j] set means entry i was written before entry j.
  logic [ENT_NUM-1:0][ENT_NUM-1:0] older, older_nxt;

  always_comb begin
    logic found, beaten;
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < ENT_NUM; i++) begin
      beaten = 1'b0;
      for (int unsigned j = 0; j < ENT_NUM; j++) begin
        if (ready[j] && older[j][i]) beaten = 1'b1;
      end
      if (!found && ready[i] && !beaten) begin
        sel   = ENT_SEL'(i);
        found = 1'b1;
      end
    end
  end

  // A new entry is younger than every entry busy at the start of the cycle; slot 1 precedes slot 2.
  always_comb begin
    older_nxt = older;
    if (wr1) begin
      for (int unsigned k = 0; k < ENT_NUM; k++) older_nxt[k][alloc1] = busy[k];
      older_nxt[alloc1] = '0;
    end
    if (wr2) begin
      for (int unsigned k = 0; k < ENT_NUM; k++)
        older_nxt[k][alloc2] = busy[k] | (wr1 && ENT_SEL'(k) == alloc1);
      older_nxt[alloc2] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) older <= '0;
    else       older <= older_nxt;
  end
`else
  always_comb begin
    logic found;
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < ENT_NUM; i++) begin
      if (!found && ready[i]) begin
        sel   = ENT_SEL'(i);
        found = 1'b1;
      end
    end
  end
`endif

  assign issue_valid = (|ready) & ~prmiss;

  always_comb begin
    issue_addr     = '0;
    ex_srcA        = '0;
    ex_srcB        = '0;
    ex_rrftag      = '0;
    ex_dstval      = 1'b0;
    ex_specbit     = 1'b0;
    ex_srcA_signed = 1'b0;
    ex_srcB_signed = 1'b0;
    ex_sel_lohi    = 1'b0;
    ex_spectag     = '0;
    if (issue_valid) begin
      issue_addr     = sel;
      ex_srcA        = hit_a[sel] ? fwd_a[sel] : ent[sel].src_a;
      ex_srcB        = hit_b[sel] ? fwd_b[sel] : ent[sel].src_b;
      ex_rrftag      = ent[sel].rrftag;
      ex_dstval      = ent[sel].dstval;
      ex_specbit     = ent[sel].specbit & ~(prsuccess && ent[sel].spectag == prtag);
      ex_srcA_signed = ent[sel].a_signed;
      ex_srcB_signed = ent[sel].b_signed;
      ex_sel_lohi    = ent[sel].sel_lohi;
      ex_spectag     = ent[sel].spectag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
      for (int unsigned i = 0; i < ENT_NUM; i++) ent[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < ENT_NUM; i++) begin
        if (hit_a[i]) begin
          ent[i].src_a   <= fwd_a[i];
          ent[i].valid_a <= 1'b1;
        end
        if (hit_b[i]) begin
          ent[i].src_b   <= fwd_b[i];
          ent[i].valid_b <= 1'b1;
        end
        if (prmiss) begin
          if (|(ent[i].spectag & specfixtag)) busy[i] <= 1'b0;
          ent[i].specbit <= 1'b0;
        end else begin
          if (prsuccess && ent[i].spectag == prtag) ent[i].specbit <= 1'b0;
          if (issue_valid && issue_ack && sel == ENT_SEL'(i)) busy[i] <= 1'b0;
          if (wr1 && alloc1 == ENT_SEL'(i)) begin
            ent[i]  <= wdata1;
            busy[i] <= 1'b1;
          end else if (wr2 && alloc2 == ENT_SEL'(i)) begin
            ent[i]  <= wdata2;
            busy[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_mul_param.sv
// tb_rs_mul_param: directed vector table, age-order sequence and randomized run against a queue-level model.
module tb_rs_mul_param;
  localparam int EN = 4, DL = 32, RS = 6, SL = 5, FN = 5;

  logic clk, reset, prmiss, prsuccess;
  logic [SL-1:0] prtag, specfixtag;
  logic we1, we2;
  logic [DL-1:0] wsrcA_1, wsrcB_1, wsrcA_2, wsrcB_2;
  logic wvalidA_1, wvalidB_1, wdstval_1, wspecbit_1, wsrcA_signed_1, wsrcB_signed_1, wsel_lohi_1;
  logic wvalidA_2, wvalidB_2, wdstval_2, wspecbit_2, wsrcA_signed_2, wsrcB_signed_2, wsel_lohi_2;
  logic [RS-1:0] wrrftag_1, wrrftag_2;
  logic [SL-1:0] wspectag_1, wspectag_2;
  logic alloc_rdy;
  logic [EN-1:0] busyvec;
  logic [FN*DL-1:0] exrslt;
  logic [FN*RS-1:0] exdst;
  logic [FN-1:0] kill_spec;
  logic issue_valid, issue_ack;
  logic [1:0] issue_addr;
  logic [DL-1:0] ex_srcA, ex_srcB;
  logic [RS-1:0] ex_rrftag;
  logic ex_dstval, ex_specbit, ex_srcA_signed, ex_srcB_signed, ex_sel_lohi;
  logic [SL-1:0] ex_spectag;

  rs_mul_param #(.ENT_NUM(EN), .DATA_LEN(DL), .RRF_SEL(RS), .SPECTAG_LEN(SL), .FWD_NUM(FN)) dut (
    .clk(clk), .reset(reset), .prmiss(prmiss), .prsuccess(prsuccess), .prtag(prtag),
    .specfixtag(specfixtag), .we1(we1), .we2(we2),
    .wsrcA_1(wsrcA_1), .wsrcB_1(wsrcB_1), .wvalidA_1(wvalidA_1), .wvalidB_1(wvalidB_1),
    .wdstval_1(wdstval_1), .wspecbit_1(wspecbit_1), .wsrcA_signed_1(wsrcA_signed_1),
    .wsrcB_signed_1(wsrcB_signed_1), .wsel_lohi_1(wsel_lohi_1), .wrrftag_1(wrrftag_1),
    .wspectag_1(wspectag_1),
    .wsrcA_2(wsrcA_2), .wsrcB_2(wsrcB_2), .wvalidA_2(wvalidA_2), .wvalidB_2(wvalidB_2),
    .wdstval_2(wdstval_2), .wspecbit_2(wspecbit_2), .wsrcA_signed_2(wsrcA_signed_2),
    .wsrcB_signed_2(wsrcB_signed_2), .wsel_lohi_2(wsel_lohi_2), .wrrftag_2(wrrftag_2),
    .wspectag_2(wspectag_2),
    .alloc_rdy(alloc_rdy), .busyvec(busyvec), .exrslt(exrslt), .exdst(exdst),
    .kill_spec(kill_spec), .issue_valid(issue_valid), .issue_ack(issue_ack),
    .issue_addr(issue_addr), .ex_srcA(ex_srcA), .ex_srcB(ex_srcB), .ex_rrftag(ex_rrftag),
    .ex_dstval(ex_dstval), .ex_specbit(ex_specbit), .ex_srcA_signed(ex_srcA_signed),
    .ex_srcB_signed(ex_srcB_signed), .ex_sel_lohi(ex_sel_lohi), .ex_spectag(ex_spectag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus (bus 3 used for forwarding) and the outputs expected in that cycle.
  typedef struct {
    int we1, we2, a, b, va, vb, sb, st1, st2, ack, fwd, ftag, fval, kill, pm, ps, mask, ptag;
    int eiv, eaddr, ea, eb, esb, ear, ebusy;
  } vec_t;

  task automatic clear_in();
    prmiss = 0; prsuccess = 0; prtag = '0; specfixtag = '0; we1 = 0; we2 = 0;
    wsrcA_1 = '0; wsrcB_1 = '0; wvalidA_1 = 0; wvalidB_1 = 0; wdstval_1 = 0; wspecbit_1 = 0;
    wsrcA_signed_1 = 0; wsrcB_signed_1 = 0; wsel_lohi_1 = 0; wrrftag_1 = '0; wspectag_1 = '0;
    wsrcA_2 = '0; wsrcB_2 = '0; wvalidA_2 = 0; wvalidB_2 = 0; wdstval_2 = 0; wspecbit_2 = 0;
    wsrcA_signed_2 = 0; wsrcB_signed_2 = 0; wsel_lohi_2 = 0; wrrftag_2 = '0; wspectag_2 = '0;
    exrslt = '0; exdst = '1; kill_spec = '0; issue_ack = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    clear_in();
    we1 = v.we1[0]; we2 = v.we2[0];
    wsrcA_1 = v.a; wsrcB_1 = v.b; wvalidA_1 = v.va[0]; wvalidB_1 = v.vb[0];
    wspecbit_1 = v.sb[0]; wspectag_1 = v.st1[SL-1:0];
    wsrcA_2 = v.a; wsrcB_2 = v.b; wvalidA_2 = v.va[0]; wvalidB_2 = v.vb[0];
    wspecbit_2 = v.sb[0]; wspectag_2 = v.st2[SL-1:0];
    issue_ack = v.ack[0];
    if (v.fwd != 0) begin
      exdst[3*RS +: RS] = v.ftag[RS-1:0];
      exrslt[3*DL +: DL] = v.fval;
      kill_spec[3] = v.kill[0];
    end
    prmiss = v.pm[0]; prsuccess = v.ps[0]; specfixtag = v.mask[SL-1:0]; prtag = v.ptag[SL-1:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_in();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("reset issue_valid", 64'(issue_valid), 0);
    check("reset busyvec", 64'(busyvec), 0);
    check("reset alloc_rdy", 64'(alloc_rdy), 1);
    check("reset ex_srcA", 64'(ex_srcA), 0);
  endtask

  // Reference model: per-entry records plus a write timestamp for age order.
  bit m_busy[EN], m_va[EN], m_vb[EN], m_sb[EN];
  logic [DL-1:0] m_a[EN], m_b[EN];
  logic [RS-1:0] m_rt[EN];
  logic [SL-1:0] m_st[EN];
  logic [3:0] m_misc[EN];
  int unsigned m_ts[EN];
  int unsigned ts_ctr;
  bit hA[EN], hB[EN];
  logic [DL-1:0] fA[EN], fB[EN];
  bit e_iv, e_ar;
  int e_sel;

  task automatic m_eval();
    bit any;
    int n_free;
    any = 0; n_free = 0; e_sel = 0;
    for (int e = 0; e < EN; e++) begin
      hA[e] = 0; hB[e] = 0; fA[e] = '0; fB[e] = '0;
      for (int j = 0; j < FN; j++) begin
        if (!kill_spec[j] && m_busy[e]) begin
          if (!hA[e] && !m_va[e] && exdst[j*RS +: RS] == m_a[e][RS-1:0]) begin
            hA[e] = 1; fA[e] = exrslt[j*DL +: DL];
          end
          if (!hB[e] && !m_vb[e] && exdst[j*RS +: RS] == m_b[e][RS-1:0]) begin
            hB[e] = 1; fB[e] = exrslt[j*DL +: DL];
          end
        end
      end
      if (!m_busy[e]) n_free++;
    end
    for (int e = 0; e < EN; e++) begin
      if (m_busy[e] && (m_va[e] || hA[e]) && (m_vb[e] || hB[e])) begin
`ifdef RS_MUL_AGE_SELECT_EN
        if (!any || m_ts[e] < m_ts[e_sel]) e_sel = e;
`else
        if (!any) e_sel = e;
`endif
        any = 1;
      end
    end
    e_iv = any && !prmiss;
    e_ar = (n_free >= 2);
  endtask

  task automatic m_write(input int e, input int slot);
    m_busy[e] = 1;
    if (slot == 1) begin
      m_a[e] = wsrcA_1; m_b[e] = wsrcB_1; m_va[e] = wvalidA_1; m_vb[e] = wvalidB_1;
      m_sb[e] = wspecbit_1; m_st[e] = wspectag_1; m_rt[e] = wrrftag_1;
      m_misc[e] = {wdstval_1, wsrcA_signed_1, wsrcB_signed_1, wsel_lohi_1};
    end else begin
      m_a[e] = wsrcA_2; m_b[e] = wsrcB_2; m_va[e] = wvalidA_2; m_vb[e] = wvalidB_2;
      m_sb[e] = wspecbit_2; m_st[e] = wspectag_2; m_rt[e] = wrrftag_2;
      m_misc[e] = {wdstval_2, wsrcA_signed_2, wsrcB_signed_2, wsel_lohi_2};
    end
    m_ts[e] = ts_ctr;
    ts_ctr++;
  endtask

  task automatic m_check(input int cyc);
    logic [DL-1:0] xa, xb;
    logic [63:0] xf;
    xa = '0; xb = '0; xf = '0;
    if (e_iv) begin
      xa = hA[e_sel] ? fA[e_sel] : m_a[e_sel];
      xb = hB[e_sel] ? fB[e_sel] : m_b[e_sel];
      xf = {m_misc[e_sel], m_sb[e_sel] && !(prsuccess && m_st[e_sel] == prtag), m_st[e_sel], m_rt[e_sel]};
    end
    check($sformatf("rnd%0d issue_valid", cyc), 64'(issue_valid), 64'(e_iv));
    check($sformatf("rnd%0d issue_addr", cyc), 64'(issue_addr), e_iv ? 64'(e_sel) : 0);
    check($sformatf("rnd%0d ex_srcA", cyc), 64'(ex_srcA), 64'(xa));
    check($sformatf("rnd%0d ex_srcB", cyc), 64'(ex_srcB), 64'(xb));
    check($sformatf("rnd%0d ex_fields", cyc),
          64'({ex_dstval, ex_srcA_signed, ex_srcB_signed, ex_sel_lohi, ex_specbit, ex_spectag, ex_rrftag}), xf);
    check($sformatf("rnd%0d alloc_rdy", cyc), 64'(alloc_rdy), 64'(e_ar));
    check($sformatf("rnd%0d busyvec", cyc), 64'(busyvec),
          64'({m_busy[3], m_busy[2], m_busy[1], m_busy[0]}));
  endtask

  task automatic m_update();
    int free_q[$];
    for (int e = 0; e < EN; e++) if (!m_busy[e]) free_q.push_back(e);
    for (int e = 0; e < EN; e++) begin
      if (hA[e]) begin m_a[e] = fA[e]; m_va[e] = 1; end
      if (hB[e]) begin m_b[e] = fB[e]; m_vb[e] = 1; end
    end
    if (prmiss) begin
      for (int e = 0; e < EN; e++) begin
        if ((m_st[e] & specfixtag) != 0) m_busy[e] = 0;
        m_sb[e] = 0;
      end
    end else begin
      if (prsuccess) for (int e = 0; e < EN; e++) if (m_st[e] == prtag) m_sb[e] = 0;
      if (e_iv && issue_ack) m_busy[e_sel] = 0;
      if (e_ar && we1) m_write(free_q[0], 1);
      if (e_ar && we2) m_write(free_q[1], 2);
    end
  endtask

  task automatic rand_inputs();
    clear_in();
    we1 = 1'($urandom_range(0, 1)); we2 = 1'($urandom_range(0, 1));
    wsrcA_1 = $urandom; wsrcB_1 = $urandom; wsrcA_2 = $urandom; wsrcB_2 = $urandom;
    wvalidA_1 = 1'($urandom_range(0, 1)); wvalidB_1 = 1'($urandom_range(0, 1));
    wvalidA_2 = 1'($urandom_range(0, 1)); wvalidB_2 = 1'($urandom_range(0, 1));
    if (!wvalidA_1) wsrcA_1[RS-1:0] = RS'($urandom_range(0, 7));
    if (!wvalidB_1) wsrcB_1[RS-1:0] = RS'($urandom_range(0, 7));
    if (!wvalidA_2) wsrcA_2[RS-1:0] = RS'($urandom_range(0, 7));
    if (!wvalidB_2) wsrcB_2[RS-1:0] = RS'($urandom_range(0, 7));
    {wdstval_1, wspecbit_1, wsrcA_signed_1, wsrcB_signed_1, wsel_lohi_1} = 5'($urandom);
    {wdstval_2, wspecbit_2, wsrcA_signed_2, wsrcB_signed_2, wsel_lohi_2} = 5'($urandom);
    wrrftag_1 = RS'($urandom); wrrftag_2 = RS'($urandom);
    wspectag_1 = SL'(1 << $urandom_range(0, SL - 1));
    wspectag_2 = SL'(1 << $urandom_range(0, SL - 1));
    for (int j = 0; j < FN; j++) begin
      exdst[j*RS +: RS] = RS'($urandom_range(0, 7));
      exrslt[j*DL +: DL] = $urandom;
      kill_spec[j] = ($urandom_range(0, 3) == 0);
    end
    issue_ack = 1'($urandom_range(0, 1));
    prmiss = ($urandom_range(0, 15) == 0);
    prsuccess = ($urandom_range(0, 7) == 0);
    prtag = SL'(1 << $urandom_range(0, SL - 1));
    specfixtag = SL'($urandom);
  endtask

  vec_t vecs[36];
  vec_t z;
  vec_t v;
  int age_first, age_second;

  initial begin
    clear_in();
    reset = 1;
    z = '{default: 0};
    //         we1 we2 a  b  va vb sb st1 st2 ack fwd ftag fval kill pm ps mask ptag | iv addr ea eb esb ear ebusy
    vecs[0]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};
    vecs[1]  = '{1,1,6,7,1,1,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};
    vecs[2]  = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,        1,0,6,7,0,1,3};
    vecs[3]  = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,        1,1,6,7,0,1,2};
    vecs[4]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};
    vecs[5]  = '{1,0,9,3,0,1,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};
    vecs[6]  = '{0,0,0,0,0,0,0,0,0,0,1,9,'h55,0,0,0,0,0,     1,0,'h55,3,0,1,1};
    vecs[7]  = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,        1,0,'h55,3,0,1,1};
    vecs[8]  = '{1,0,9,3,0,1,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};
    vecs[9]  = '{0,0,0,0,0,0,0,0,0,0,1,9,'h55,1,0,0,0,0,     0,0,0,0,0,1,1};
    vecs[10] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,1};
    vecs[11] = '{0,0,0,0,0,0,0,0,0,1,1,9,'h66,0,0,0,0,0,     1,0,'h66,3,0,1,1};
    vecs[12] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};
    vecs[13] = '{1,1,1,2,1,1,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};
    vecs[14] = '{1,1,1,2,1,1,0,0,0,0,0,0,0,0,0,0,0,0,        1,0,1,2,0,1,3};
    vecs[15] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        1,0,1,2,0,0,15};
    vecs[16] = '{1,0,1,2,1,1,0,0,0,1,0,0,0,0,0,0,0,0,        1,0,1,2,0,0,15};
    vecs[17] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,        1,1,1,2,0,0,14};
    vecs[18] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        1,2,1,2,0,1,12};
    vecs[19] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,        1,2,1,2,0,1,12};
    vecs[20] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,        1,3,1,2,0,1,8};
    vecs[21] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};
    vecs[22] = '{1,1,4,5,1,1,1,2,1,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};
    vecs[23] = '{1,0,8,9,1,1,0,0,0,0,0,0,0,0,1,0,2,0,        0,0,0,0,0,1,3};
    vecs[24] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        1,1,4,5,0,1,2};
    vecs[25] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,        1,1,4,5,0,1,2};
    vecs[26] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};
    vecs[27] = '{1,0,10,11,1,1,1,1,0,0,0,0,0,0,0,0,0,0,      0,0,0,0,0,1,0};
    vecs[28] = '{1,0,12,13,1,1,1,2,0,0,0,0,0,0,0,1,0,1,      1,0,10,11,0,1,1};
    vecs[29] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        1,0,10,11,0,1,3};
    vecs[30] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,        1,0,10,11,0,1,3};
    vecs[31] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,        1,1,12,13,1,1,2};
    vecs[32] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};
    vecs[33] = '{0,1,20,21,1,1,0,0,0,0,0,0,0,0,0,0,0,0,      0,0,0,0,0,1,0};
    vecs[34] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,        1,1,20,21,0,1,2};
    vecs[35] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,        0,0,0,0,0,1,0};

    do_reset();

    for (int n = 0; n < 36; n++) begin
      @(negedge clk);
      apply_vec(vecs[n]);
      #1;
      check($sformatf("row%0d issue_valid", n), 64'(issue_valid), 64'(vecs[n].eiv));
      check($sformatf("row%0d issue_addr", n), 64'(issue_addr), 64'(vecs[n].eaddr));
      check($sformatf("row%0d ex_srcA", n), 64'(ex_srcA), 64'(vecs[n].ea));
      check($sformatf("row%0d ex_srcB", n), 64'(ex_srcB), 64'(vecs[n].eb));
      check($sformatf("row%0d ex_specbit", n), 64'(ex_specbit), 64'(vecs[n].esb));
      check($sformatf("row%0d alloc_rdy", n), 64'(alloc_rdy), 64'(vecs[n].ear));
      check($sformatf("row%0d busyvec", n), 64'(busyvec), 64'(vecs[n].ebusy));
    end

    // Age order: entry 2 is written before entry 0 is refilled, then both wake on the same bus.
`ifdef RS_MUL_AGE_SELECT_EN
    age_first = 2; age_second = 0;
`else
    age_first = 0; age_second = 2;
`endif
    v = z; v.we1 = 1; v.we2 = 1; v.a = 9; v.b = 1; v.vb = 1; v.st1 = 4; v.st2 = 4;
    @(negedge clk); apply_vec(v);
    v = z; v.we1 = 1; v.a = 9; v.b = 1; v.vb = 1;
    @(negedge clk); apply_vec(v);
    v = z; v.pm = 1; v.mask = 4;
    @(negedge clk); apply_vec(v);
    v = z; v.we1 = 1; v.a = 9; v.b = 1; v.vb = 1;
    @(negedge clk); apply_vec(v);
    v = z; v.fwd = 1; v.ftag = 9; v.fval = 'h77; v.ack = 1;
    @(negedge clk); apply_vec(v);
    #1;
    check("age busyvec", 64'(busyvec), 64'b0101);
    check("age issue_valid", 64'(issue_valid), 1);
    check("age first addr", 64'(issue_addr), 64'(age_first));
    check("age fwd srcA", 64'(ex_srcA), 'h77);
    v = z; v.ack = 1;
    @(negedge clk); apply_vec(v);
    #1;
    check("age second addr", 64'(issue_addr), 64'(age_second));
    check("age second srcA", 64'(ex_srcA), 'h77);
    @(negedge clk); apply_vec(z);
    #1;
    check("age drained", 64'(busyvec), 0);

    do_reset();
    for (int e = 0; e < EN; e++) begin
      m_busy[e] = 0; m_va[e] = 0; m_vb[e] = 0; m_sb[e] = 0; m_a[e] = '0; m_b[e] = '0;
      m_rt[e] = '0; m_st[e] = '0; m_misc[e] = '0; m_ts[e] = 0;
    end
    ts_ctr = 1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rand_inputs();
      #1;
      m_eval();
      m_check(c);
      m_update();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
